dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Parametrised, handshaked data memory for the RV32 core's load/store path.
//  - Adds sub-word access (byte/half/word with sign/zero extension), alignment checks and configurable wait states.
//  - Clears its storage after reset with a sequencer instead of a one-cycle array reset.
//  - One request outstanding at a time, serviced through a small FSM.
// PARAMETERS
//  DEPTH        64   number of 32-bit words; power of 2, >= 4
//  WAIT_STATES  0    extra cycles between acceptance and access, 0..15
//  ADDR_W       32   byte-address width on req_addr
// PORTS
//  clk          in   1       clock, all state on rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when req_valid & req_ready
//  req_we       in   1       1 = store, 0 = load
//  req_funct3   in   3       RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr     in   ADDR_W  byte address
//  req_wdata    in   32      store data, right-aligned (SB uses [7:0], SH uses [15:0])
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       response consumed when rsp_valid & rsp_ready
//  rsp_rdata    out  32      load result, extended per funct3; 0 for stores and errors
//  rsp_err      out  1       request rejected: misaligned, illegal funct3 or out of range
//  init_done    out  1       high once the clear sequence has completed
// BEHAVIOUR
//  - Reset (reset_n low, takes effect immediately):
//    - state = INIT, clear pointer = 0.
//    - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_done = 0.
//    - Storage is not reset asynchronously.
//  - FSM states: INIT -> IDLE -> BUSY -> RESP -> IDLE.
//    - INIT: writes 0 to word[ptr] each cycle, ptr++.
//      - After word DEPTH-1 is written: init_done = 1, go to IDLE.
//      - INIT therefore lasts exactly DEPTH cycles.
//    - IDLE: req_ready = 1, and only in IDLE.
//      - On acceptance: latch we, funct3, addr, wdata; load cnt = WAIT_STATES; go to BUSY.
//    - BUSY: if cnt != 0, cnt--.
//      - If cnt == 0 on an edge: perform the access on that edge, register rsp_rdata and rsp_err, go to RESP.
//      - rsp_valid rises exactly WAIT_STATES+1 cycles after the acceptance edge.
//    - RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
//      - On handshake: rsp_valid = 0, go to IDLE.
//      - Minimum request-to-request spacing is WAIT_STATES+3 cycles.
//  - Addressing:
//    - word index = addr[$clog2(DEPTH)+1:2]
//    - byte lane = addr[1:0]
//  - Errors (rsp_err = 1, no write, rsp_rdata = 0):
//    - funct3 in {011, 110, 111};
//    - funct3 == 101 with req_we = 1;
//    - halfword access with addr[0] = 1;
//    - word access with addr[1:0] != 0.
//  - Stores: only the addressed bytes change; all other bytes of the word keep their value.
//  - Loads:
//    - B/H: sign-extend from bit 7/15;
//    - BU/HU: zero-extend;
//    - W: pass through.
//  - Reset asserted during BUSY or RESP aborts the request, and any pending store is dropped.
//    - If the abort hits the access edge, the write is still blocked.
//    - INIT then re-clears the whole array.
//  - req_valid is ignored outside IDLE; no request is queued.
// CONFIGURATION
//  - DMEM_BOUNDS_CHECK_EN defined:
//    - addr >= 4*DEPTH gives rsp_err = 1 with no access.
//    - This check has priority equal to the misalignment check.
//  - DMEM_BOUNDS_CHECK_EN undefined:
//    - address bits above $clog2(DEPTH)+1 are ignored, so accesses wrap modulo 4*DEPTH.
//    - rsp_err is set only for misalignment or an illegal funct3.
// TESTING
//  1. Reset, DEPTH=64: init_done rises 64 cycles after reset_n goes high; a LW of every word returns 0.
//  2. Sub-word loads:
//     - SW 0x8000_80FF @0x10; LB @0x10 -> 0xFFFF_FFFF; LBU @0x10 -> 0x0000_00FF;
//     - LH @0x12 -> 0xFFFF_8000; LHU @0x12 -> 0x0000_8000.
//  3. Byte merge: SW 0x1122_3344 @0x20; SB 0xAA @0x21; LW @0x20 -> 0x1122_AA44.
//  4. Errors:
//     - LW @0x22 -> rsp_err = 1, rsp_rdata = 0;
//     - SH @0x23 -> rsp_err = 1, and a following LW @0x20 shows the word unchanged.
//  5. Timing and backpressure, WAIT_STATES=3:
//     - rsp_valid rises 4 cycles after acceptance;
//     - with rsp_ready held low 5 cycles: outputs stable, req_ready stays 0.
//  6. Abort and range:
//     - reset_n pulsed low while a store is in BUSY: the store is not written and init_done drops.
//     - Range, per build:
//       - with DMEM_BOUNDS_CHECK_EN: LW @0x100 -> rsp_err = 1;
//       - without DMEM_BOUNDS_CHECK_EN: LW @0x100 returns word 0.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Request/response bus for the RV32 data memory.
// master: core side (drives req_*, rsp_ready); slave: dmem_ctrl.
interface dmem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3,
        output req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3,
        input  req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Handshaked RV32 data memory: B/H/W access, alignment checks, wait states,
// and a post-reset clear sequencer. Optional range check: DMEM_BOUNDS_CHECK_EN.
// Ports: clk, reset_n (async, active-low), bus (dmem_ctrl_if.slave:
// req_valid/ready/we/funct3/addr/wdata, rsp_valid/ready/rdata/err), init_done.
module dmem_ctrl #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    dmem_ctrl_if.slave  bus,
    output logic        init_done
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_INIT, S_IDLE, S_BUSY, S_RESP
    } state_t;

    state_t state, state_nx;

    logic [IW-1:0]     ptr;
    logic [3:0]        cnt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       mem [DEPTH];

    logic [IW-1:0] widx;
    logic [1:0]    lane;
    logic          acc;
    logic          hi;
    logic          oob;
    logic          bad_f3;
    logic          mis;
    logic          err;
    logic [31:0]   word;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic [31:0]   ext;
    logic [31:0]   rd_val;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          wr_en;

`ifndef DMEM_BOUNDS_CHECK_EN
    logic range_unused;
    assign range_unused = hi;
`endif

    always_comb begin
        widx   = addr_q[IW+1:2];
        lane   = addr_q[1:0];
        acc    = (state == S_BUSY) && (cnt == 4'd0);
        hi     = |(addr_q >> (IW + 2));
`ifdef DMEM_BOUNDS_CHECK_EN
        oob    = hi;
`else
        oob    = 1'b0;
`endif
        bad_f3 = (f3_q == 3'b011) || (f3_q[2:1] == 2'b11)
              || ((f3_q == 3'b101) && we_q);
        mis    = ((f3_q[1:0] == 2'b01) && lane[0])
              || ((f3_q[1:0] == 2'b10) && (lane != 2'b00));
        err    = bad_f3 || mis || oob;
    end

    // Read extraction and sign/zero extension
    always_comb begin
        word = mem[widx];
        bsel = word[{lane, 3'b000} +: 8];
        hsel = lane[1] ? word[31:16] : word[15:0];
        ext  = '0;
        unique case (f3_q)
            3'b000:  ext = {{24{bsel[7]}}, bsel};
            3'b001:  ext = {{16{hsel[15]}}, hsel};
            3'b010:  ext = word;
            3'b100:  ext = {24'b0, bsel};
            3'b101:  ext = {16'b0, hsel};
            default: ext = '0;
        endcase
        rd_val = (err || we_q) ? 32'b0 : ext;
    end

    // Store data replicated across lanes; byte enables pick the target
    always_comb begin
        be = 4'b0000;
        wd = wdata_q;
        unique case (f3_q[1:0])
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_q[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        // reset_n gate blocks a store whose access edge meets reset
        wr_en = acc && we_q && !err && reset_n;
    end

    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[ptr] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_INIT;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state)
            S_INIT: begin
                if (ptr == IW'(DEPTH - 1)) state_nx = S_IDLE;
            end
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_nx = S_BUSY;
            end
            S_BUSY: begin
                if (cnt == 4'd0) state_nx = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            cnt       <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            init_done <= 1'b0;
        end else begin
            unique case (state)
                S_INIT: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == IW'(DEPTH - 1)) init_done <= 1'b1;
                end
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        cnt     <= 4'(WAIT_STATES);
                    end
                end
                S_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rdata_q <= rd_val;
                        err_q   <= err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (DEPTH=64, WAIT_STATES=3).
// Expected responses are queued at request time and compared on handshake.
module tb_dmem_ctrl;
    localparam int DEPTH = 64;
    localparam int WS    = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic init_done;

    always #5 clk = ~clk;

    dmem_ctrl_if #(.ADDR_W(32)) bus ();

    dmem_ctrl #(
        .DEPTH(DEPTH),
        .WAIT_STATES(WS),
        .ADDR_W(32)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus),
        .init_done(init_done)
    );

    int n_chk = 0;
    int n_pass = 0;
    logic [32:0] sb[$];
    logic [32:0] e;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rdata", bus.rsp_rdata, e[31:0]);
                chk("err", {31'b0, bus.rsp_err}, {31'b0, e[32]});
            end
        end
    end

    task automatic do_reset();
        int n;
        reset_n = 1'b0;
        #2;
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        chk("rst_init_done", {31'b0, init_done}, 32'd0);
        sb.delete();
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (init_done) break;
        end
        chk("init_lat", 32'(n), 32'(DEPTH));
    endtask

    task automatic drive(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr,
                        input int hold);
        int n;
        @(posedge clk);
        #1;
        drive(we, f3, a, wd);
        bus.rsp_ready = (hold == 0);
        sb.push_back({eerr, erd});
        wait_accept();
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        chk("lat", 32'(n), 32'(WS + 1));
        #1;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                chk("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
                chk("hold_rdata", bus.rsp_rdata, erd);
                chk("hold_err", {31'b0, bus.rsp_err}, {31'b0, eerr});
                chk("hold_req_ready", {31'b0, bus.req_ready}, 32'd0);
                @(negedge clk);
                #1;
            end
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            #1;
        end
        chk("rsp_done", 32'(sb.size()), 32'd0);
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.rsp_ready  = 1'b0;
        #12;
        do_reset();

        for (int i = 0; i < DEPTH; i++)
            xact(1'b0, 3'b010, 32'(i * 4), 32'd0, 32'd0, 1'b0, 0);

        xact(1'b1, 3'b010, 32'h10, 32'h8000_80FF, 32'd0, 1'b0, 0);
        xact(1'b0, 3'b000, 32'h10, 32'd0, 32'hFFFF_FFFF, 1'b0, 0);
        xact(1'b0, 3'b100, 32'h10, 32'd0, 32'h0000_00FF, 1'b0, 0);
        xact(1'b0, 3'b001, 32'h12, 32'd0, 32'hFFFF_8000, 1'b0, 0);
        xact(1'b0, 3'b101, 32'h12, 32'd0, 32'h0000_8000, 1'b0, 0);

        xact(1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'd0, 1'b0, 0);
        xact(1'b1, 3'b000, 32'h21, 32'h0000_00AA, 32'd0, 1'b0, 0);
        xact(1'b0, 3'b010, 32'h20, 32'd0, 32'h1122_AA44, 1'b0, 0);

        xact(1'b0, 3'b010, 32'h22, 32'd0, 32'd0, 1'b1, 0);
        xact(1'b1, 3'b001, 32'h23, 32'h5555, 32'd0, 1'b1, 0);
        xact(1'b0, 3'b010, 32'h20, 32'd0, 32'h1122_AA44, 1'b0, 0);

        xact(1'b1, 3'b001, 32'h22, 32'h1234_BEEF, 32'd0, 1'b0, 0);
        xact(1'b0, 3'b010, 32'h20, 32'd0, 32'hBEEF_AA44, 1'b0, 0);
        xact(1'b0, 3'b000, 32'h23, 32'd0, 32'hFFFF_FFBE, 1'b0, 0);
        xact(1'b0, 3'b101, 32'h22, 32'd0, 32'h0000_BEEF, 1'b0, 0);

        xact(1'b0, 3'b011, 32'h20, 32'd0, 32'd0, 1'b1, 0);
        xact(1'b0, 3'b110, 32'h20, 32'd0, 32'd0, 1'b1, 0);
        xact(1'b1, 3'b101, 32'h20, 32'h7777, 32'd0, 1'b1, 0);
        xact(1'b0, 3'b010, 32'h20, 32'd0, 32'hBEEF_AA44, 1'b0, 0);

        xact(1'b0, 3'b010, 32'h10, 32'd0, 32'h8000_80FF, 1'b0, 5);

        @(posedge clk);
        #1;
        drive(1'b1, 3'b010, 32'h30, 32'hDEAD_BEEF);
        bus.rsp_ready = 1'b1;
        wait_accept();
        @(posedge clk);
        #1;
        do_reset();
        xact(1'b0, 3'b010, 32'h30, 32'd0, 32'd0, 1'b0, 0);
        xact(1'b0, 3'b010, 32'h10, 32'd0, 32'd0, 1'b0, 0);

        xact(1'b1, 3'b010, 32'h0, 32'hCAFE_F00D, 32'd0, 1'b0, 0);
`ifdef DMEM_BOUNDS_CHECK_EN
        xact(1'b0, 3'b010, 32'h100, 32'd0, 32'd0, 1'b1, 0);
`else
        xact(1'b0, 3'b010, 32'h100, 32'd0, 32'hCAFE_F00D, 1'b0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
